// File: rtl/instr_fetch.sv
// instr_fetch: PC owner driving a 1-cycle synchronous ROM, with valid/ready output, redirects and halt gating
module instr_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h01000000,
  parameter int PC_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic                  read_instr,
  output logic [DATA_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] rom_data_in,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_plus4_out,
  output logic                  err_misaligned,
  output logic [31:0]           fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc_q, pc_out_q;
  logic out_valid_q, err_q, misaligned, xfer;
  logic [31:0] fetch_count_q;
  always_comb begin
    misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
    read_instr = (state == RUN) & !rst & !halt_req & !misaligned & (!out_valid_q | dec_ready | redirect_valid);
    addr_out = redirect_valid ? redirect_pc : pc_q;
    instr_valid = out_valid_q & !redirect_valid;
    xfer = instr_valid & dec_ready;
    state_n = misaligned ? HALT : state;
  end
  assign instr_out = rom_data_in;
  assign pc_out = pc_out_q;
  assign pc_plus4_out = pc_out_q + DATA_WIDTH'(4);
  assign err_misaligned = err_q;
  assign fetch_count = fetch_count_q;
  always_ff @(posedge clk) state <= rst ? RUN : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      pc_out_q <= '0;
      out_valid_q <= 1'b0;
      err_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (xfer) fetch_count_q <= fetch_count_q + 32'd1;
      if (read_instr) begin
        pc_out_q <= addr_out;
        pc_q <= addr_out + DATA_WIDTH'(PC_STEP);
        out_valid_q <= 1'b1;
      end else if (misaligned) begin
        out_valid_q <= 1'b0;
        err_q <= 1'b1;
      end else if (redirect_valid) begin
        // redirect while issue is gated: remember the target for when fetch resumes
        pc_q <= redirect_pc;
        out_valid_q <= 1'b0;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a 1-cycle ROM model
module tb_instr_fetch;
  localparam logic [31:0] B = 32'h01000000;
  logic clk = 0, rst = 1, halt_req = 0, redirect_valid = 0, dec_ready = 0;
  logic [31:0] redirect_pc = 0, rom_data_in = 0;
  logic read_instr, instr_valid, err_misaligned;
  logic [31:0] addr_out, instr_out, pc_out, pc_plus4_out, fetch_count;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_ready(dec_ready), .read_instr(read_instr),
    .addr_out(addr_out), .rom_data_in(rom_data_in), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .err_misaligned(err_misaligned), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) if (read_instr) rom_data_in <= rom(addr_out);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && dec_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_xfer", pc_out, 32'hFFFFFFFF);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", pc_out, e);
        check("sb_instr", instr_out, rom(e));
        check("sb_pc4", pc_plus4_out, e + 32'd4);
      end
    end
  end

  task automatic cyc(input logic r, input logic h, input logic rv, input logic [31:0] rp, input logic d);
    @(posedge clk);
    #1;
    rst = r; halt_req = h; redirect_valid = rv; redirect_pc = rp; dec_ready = d;
    @(negedge clk);
  endtask

  task automatic io(input string tag, input logic rd, input logic [31:0] a, input logic iv);
    check({tag, "_read"}, {31'd0, read_instr}, {31'd0, rd});
    if (rd) check({tag, "_addr"}, addr_out, a);
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, iv});
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    io("reset", 0, 0, 0);
    check("reset_count", fetch_count, 0);
    check("reset_err", {31'd0, err_misaligned}, 0);
    exp_q.push_back(B); exp_q.push_back(B + 4); exp_q.push_back(B + 8);
    cyc(0, 0, 0, 0, 1); io("seq0", 1, B, 0);
    cyc(0, 0, 0, 0, 1); io("seq1", 1, B + 4, 1);
    check("seq1_pc", pc_out, B);
    check("seq1_pc4", pc_plus4_out, B + 4);
    cyc(0, 0, 0, 0, 1); io("seq2", 1, B + 8, 1);
    cyc(0, 0, 0, 0, 1); io("seq3", 1, B + 12, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0); io("stall", 0, 0, 1);
      check("stall_pc", pc_out, B + 12);
      check("stall_instr", instr_out, rom(B + 12));
      check("stall_count", fetch_count, 3);
    end
    exp_q.push_back(B + 12); exp_q.push_back(B + 16);
    cyc(0, 0, 0, 0, 1); io("resume", 1, B + 16, 1);
    cyc(0, 0, 0, 0, 1); io("resume2", 1, B + 20, 1);
    exp_q.push_back(B + 32'h40); exp_q.push_back(B + 32'h44);
    cyc(0, 0, 1, B + 32'h40, 1); io("redir", 1, B + 32'h40, 0);
    check("redir_count", fetch_count, 5);
    cyc(0, 0, 0, 0, 1); io("redir1", 1, B + 32'h44, 1);
    check("redir1_count", fetch_count, 5);
    cyc(0, 0, 0, 0, 1); io("redir2", 1, B + 32'h48, 1);
    cyc(0, 0, 0, 0, 0); check("redir_count2", fetch_count, 7);
    exp_q.push_back(B + 32'h48);
    cyc(0, 1, 0, 0, 0); io("halt_pend", 0, 0, 1);
    cyc(0, 1, 0, 0, 1); io("halt_xfer", 0, 0, 1);
    cyc(0, 1, 0, 0, 1); io("halt_idle", 0, 0, 0);
    check("halt_count", fetch_count, 8);
    cyc(0, 1, 1, B + 32'h80, 1); io("halt_redir", 0, 0, 0);
    cyc(0, 1, 0, 0, 1); io("halt_idle2", 0, 0, 0);
    exp_q.push_back(B + 32'h80); exp_q.push_back(B + 32'h84);
    cyc(0, 0, 0, 0, 1); io("unhalt", 1, B + 32'h80, 0);
    cyc(0, 0, 0, 0, 1); io("unhalt1", 1, B + 32'h84, 1);
    cyc(0, 0, 0, 0, 1); io("unhalt2", 1, B + 32'h88, 1);
    cyc(0, 0, 0, 0, 0); check("pre_rst_count", fetch_count, 10);
    check("pre_rst_pc", pc_out, B + 32'h88);
    cyc(1, 0, 0, 0, 1); check("rst_read", {31'd0, read_instr}, 0);
    cyc(0, 0, 0, 0, 0); io("post_rst", 1, B, 0);
    check("post_rst_count", fetch_count, 0);
    cyc(0, 0, 1, B + 32'h42, 1); io("mis", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1); io("mis_halt", 0, 0, 0);
      check("mis_err", {31'd0, err_misaligned}, 1);
    end
    cyc(0, 0, 1, B + 32'h100, 1); io("mis_redir", 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    exp_q.push_back(B);
    cyc(0, 0, 0, 0, 1); io("clr", 1, B, 0);
    check("clr_err", {31'd0, err_misaligned}, 0);
    cyc(0, 0, 0, 0, 1); io("clr1", 1, B + 4, 1);
    cyc(0, 0, 0, 0, 0);
    check("sb_drained", exp_q.size(), 0);
    check("final_count", fetch_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
